shift_unit_arbiter: RTL and testbench
=====================================

# shift_unit_arbiter

Sequencing and arbitration controller that shares one combinational SRL/SRA shift unit between two requesters (port 0: ALU issue, port 1: address/immediate path). Accepts one operation at a time over valid/ready, grants round-robin, holds registered operands on the shifter for a fixed number of cycles, captures the result, and returns it to the winning requester with a valid/ready response handshake. It sits between the execute-stage requesters and the shared shifter instance.

## Interface
- SHIFT_LAT, 1, cycles the shifter output needs to settle before capture; legal range 1..15
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  controller accepts requester N this cycle
- req0_a / req1_a  in  32  operand to shift
- req0_b / req1_b  in  32  shift amount; only [4:0] used
- req0_arith / req1_arith  in  1  0 = logical (SRL), 1 = arithmetic (SRA)
- resp0_valid / resp1_valid  out  1  result for requester N available
- resp0_ready / resp1_ready  in  1  requester N takes the result
- resp_data  out  32  result, shared by both response ports
- sh_a  out  32  operand to shared shifter
- sh_b  out  32  shift amount to shifter, bits [31:5] driven 0
- sh_sel  out  1  shifter select (0 SRL, 1 SRA)
- sh_d  in  32  shifter result

## Operation
- States: IDLE, EXEC, RESP. Reset -> IDLE.
- IDLE: reqN_ready = 1 only for the granted requester; other ready = 0. Grant: if only one valid, that one; if both valid, the one not granted last (last_grant pointer, reset to 1 so port 0 wins first). Handshake (valid & ready) at edge: latch a, b[4:0], arith into sh_a/sh_b/sh_sel, record owner, update last_grant, load counter = SHIFT_LAT-1, go EXEC.
- EXEC: operands held stable; counter decrements each cycle; when counter = 0, capture sh_d into resp_data, go RESP.
- RESP: respN_valid = 1 for owner only; resp_data held stable. On respN_valid & respN_ready -> IDLE. No new request accepted in EXEC or RESP (single outstanding).
- Requester without valid never affects last_grant. Valid may drop before ready without penalty (no request lost or duplicated; nothing latched).
- Reset mid-operation: in-flight op discarded, no response issued, pointer returns to favour port 0.
- Reset values: req0_ready, req1_ready, resp0_valid, resp1_valid = 0; resp_data, sh_a, sh_b = 0; sh_sel = 0. Ready outputs forced 0 while rst is high.

## Timing
- Accept at edge T; EXEC occupies SHIFT_LAT cycles; respN_valid high from edge T+SHIFT_LAT+... i.e. first response cycle = SHIFT_LAT+1 cycles after the accept cycle (SHIFT_LAT=1: accept cycle 0, EXEC cycle 1, resp_valid cycle 2).
- resp_ready asserted in first RESP cycle -> IDLE next cycle; next accept earliest one cycle later. Throughput: one op per SHIFT_LAT+2 cycles with no backpressure.
- reqN_ready is combinational from state, last_grant and req valids; no path from reqN_a/b to any output.
- resp_data, sh_a, sh_b, sh_sel are registered outputs.

## Configuration
- SHIFT_ARB_ZERO_BYPASS_EN defined: on accept with b[4:0] = 0, resp_data loaded with operand a directly and FSM goes IDLE -> RESP, skipping EXEC (response one cycle after accept); sh_a/sh_b/sh_sel still updated.
- Not defined: zero-amount shifts take the normal EXEC path; latency identical for all amounts.

## Test plan
- Port 0 only, a=0x80000000, b=4, arith=0, SHIFT_LAT=1 -> resp0_valid two cycles after accept, resp_data=0x08000000, resp1_valid stays 0.
- Port 1 only, a=0x80000000, b=0x24 (upper bits ignored), arith=1 -> sh_b=4, resp_data=0xF8000000 on resp1.
- Both valid continuously from reset, four ops -> grants 0,1,0,1; each response on the owning port only.
- resp0_ready held 0 for 5 cycles -> resp0_valid and resp_data stable, both reqN_ready 0 throughout; release -> IDLE next cycle.
- rst pulsed during EXEC with SHIFT_LAT=3 -> all outputs 0, no response; next simultaneous request granted to port 0.
- b=0, a=0x1234_5678: with SHIFT_ARB_ZERO_BYPASS_EN response 1 cycle after accept; without it SHIFT_LAT+1 cycles; resp_data=0x12345678 both cases.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
// Round-robin sharing of one SRL/SRA shifter between two requesters; one op in flight; result after SHIFT_LAT+1 cycles.
// Response is held until the owner's ready; SHIFT_ARB_ZERO_BYPASS_EN returns zero-amount shifts one cycle after accept.
module shift_unit_arbiter #(
    parameter int SHIFT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_arith,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_arith,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic        sh_sel,
    input  logic [31:0] sh_d
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  amt;
        logic        arith;
    } op_t;

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic [3:0]  cnt;
    logic [4:0]  sh_amt;
    logic        grant0;
    logic        grant1;
    op_t         sel_op;
    logic        unused_b_hi;

    // Port 0 wins a tie when port 1 was granted last, and vice versa.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        sel_op = '0;
        if (grant1) begin
            sel_op.a     = req1_a;
            sel_op.amt   = req1_b[4:0];
            sel_op.arith = req1_arith;
        end else begin
            sel_op.a     = req0_a;
            sel_op.amt   = req0_b[4:0];
            sel_op.arith = req0_arith;
        end
    end

    assign req0_ready  = ~rst & (state == IDLE) & grant0;
    assign req1_ready  = ~rst & (state == IDLE) & grant1;
    assign resp0_valid = (state == RESP) & ~owner;
    assign resp1_valid = (state == RESP) & owner;
    assign sh_b        = {27'd0, sh_amt};
    assign unused_b_hi = ^{req0_b[31:5], req1_b[31:5]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            resp_data  <= '0;
            sh_a       <= '0;
            sh_amt     <= '0;
            sh_sel     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        sh_a       <= sel_op.a;
                        sh_amt     <= sel_op.amt;
                        sh_sel     <= sel_op.arith;
                        cnt        <= 4'(SHIFT_LAT - 1);
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
                        if (sel_op.amt == 5'd0) begin
                            resp_data <= sel_op.a;
                            state     <= RESP;
                        end else begin
                            state     <= EXEC;
                        end
`else
                        state      <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        resp_data <= sh_d;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner ? resp1_ready : resp0_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: directed cases plus random traffic against a transaction-level reference model.
module tb_shift_unit_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_arith;
    logic        req1_valid, req1_ready, req1_arith;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_data, sh_a, sh_b, sh_d;
    logic        sh_sel;

    always #5 clk = ~clk;

    // Stand-in for the shared shifter instance.
    assign sh_d = sh_sel ? 32'($signed(sh_a) >>> sh_b[4:0]) : (sh_a >> sh_b[4:0]);

    shift_unit_arbiter #(.SHIFT_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_arith(req0_arith),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_arith(req1_arith),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .sh_a(sh_a), .sh_b(sh_b), .sh_sel(sh_sel), .sh_d(sh_d)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stimulus state applied at each negedge.
    logic        rst_d, v0, v1, ar0, ar1, rr0, rr1;
    logic [31:0] a0, a1, b0, b1;

    // Reference model state.
    int          cyc = 0;
    bit          busy, m_owner, last_win;
    int          resp_at, acc_cyc;
    logic [31:0] m_a, m_b, m_data, tb_b;
    bit          m_sel;
    bit          acc_ev, acc_port, resp_ev, resp_port;
    logic [31:0] resp_val;

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n, input bit ar);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < int'(n); i++) r = {ar & r[31], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] rand_b();
        if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFE0;
        return $urandom;
    endfunction

    task automatic new_op(input bit p);
        if (p) begin a1 = $urandom; b1 = rand_b(); ar1 = 1'($urandom_range(0, 1)); end
        else   begin a0 = $urandom; b0 = rand_b(); ar0 = 1'($urandom_range(0, 1)); end
    endtask

    task automatic step();
        bit e0, e1;
        @(negedge clk);
        rst = rst_d;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_arith = ar0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_arith = ar1;
        resp0_ready = rr0; resp1_ready = rr1;
        #1;
        acc_ev = 0;
        resp_ev = 0;
        if (rst) begin
            check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            check("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
            check("rst_resp_data", resp_data, 32'd0);
            check("rst_sh_a", sh_a, 32'd0);
            check("rst_sh_b", sh_b, 32'd0);
            check("rst_sh_sel", {31'd0, sh_sel}, 32'd0);
            busy = 0;
            last_win = 1;
        end else if (!busy) begin
            e0 = v0 && (!v1 || last_win);
            e1 = v1 && (!v0 || !last_win);
            check("ready0", {31'd0, req0_ready}, {31'd0, e0});
            check("ready1", {31'd0, req1_ready}, {31'd0, e1});
            check("idle_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
            if (e0 || e1) begin
                m_owner = e1;
                m_a     = e1 ? a1 : a0;
                tb_b    = e1 ? b1 : b0;
                m_b     = {27'd0, tb_b[4:0]};
                m_sel   = e1 ? ar1 : ar0;
                m_data  = ref_shift(m_a, m_b[4:0], m_sel);
                resp_at = cyc + LAT + 1;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
                if (m_b == 32'd0) resp_at = cyc + 1;
`endif
                last_win = m_owner;
                busy     = 1;
                acc_ev   = 1;
                acc_port = m_owner;
                acc_cyc  = cyc;
            end
        end else begin
            check("busy_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            check("sh_a", sh_a, m_a);
            check("sh_b", sh_b, m_b);
            check("sh_sel", {31'd0, sh_sel}, {31'd0, m_sel});
            if (cyc >= resp_at) begin
                check("resp_valid", {30'd0, resp1_valid, resp0_valid}, m_owner ? 32'd2 : 32'd1);
                check("resp_data", resp_data, m_data);
                if (m_owner ? rr1 : rr0) begin
                    busy      = 0;
                    resp_ev   = 1;
                    resp_port = m_owner;
                    resp_val  = resp_data;
                end
            end else begin
                check("early_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
            end
        end
        cyc++;
    endtask

    task automatic wait_acc(input string tag);
        int n = 0;
        step();
        while (!acc_ev && n < 20) begin step(); n++; end
        check({tag, "_accepted"}, {31'd0, acc_ev}, 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        step();
        while (!resp_ev && n < 60) begin step(); n++; end
        check({tag, "_responded"}, {31'd0, resp_ev}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        while (busy && n < 60) begin step(); n++; end
        check("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_single(input bit p, input logic [31:0] a, input logic [31:0] b, input bit ar,
                              input logic [31:0] expd, input string tag);
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        if (p) begin v1 = 1; a1 = a; b1 = b; ar1 = ar; end
        else   begin v0 = 1; a0 = a; b0 = b; ar0 = ar; end
        wait_acc(tag);
        v0 = 0; v1 = 0;
        wait_resp(tag);
        check({tag, "_port"}, {31'd0, resp_port}, {31'd0, p});
        check({tag, "_data"}, resp_val, expd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, n;
        rst = 1; rst_d = 1;
        v0 = 1; v1 = 1; a0 = 32'hDEAD_BEEF; b0 = 32'd3; ar0 = 0; a1 = 32'hCAFE_F00D; b1 = 32'd7; ar1 = 1;
        rr0 = 1; rr1 = 1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_arith = 0;
        req1_a = 0; req1_b = 0; req1_arith = 0; resp0_ready = 0; resp1_ready = 0;
        busy = 0; last_win = 1;
        step(); step();
        rst_d = 0;
        v0 = 0; v1 = 0;
        step();

        run_single(0, 32'h8000_0000, 32'd4, 0, 32'h0800_0000, "srl_port0");
        run_single(1, 32'h8000_0000, 32'h24, 1, 32'hF800_0000, "sra_port1");

        // Both requesters valid continuously from reset: grants must alternate starting at port 0.
        rst_d = 1; step(); rst_d = 0;
        new_op(0); new_op(1); v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
        g = 0; n = 0;
        while (g < 4 && n < 100) begin
            step();
            if (acc_ev) begin
                check($sformatf("rr_grant%0d", g), {31'd0, acc_port}, g % 2);
                new_op(acc_port);
                g++;
            end
            n++;
        end
        check("rr_grant_count", g, 32'd4);
        drain();

        // Response backpressure with the other port waiting.
        v0 = 1; a0 = 32'h0F0F_0000; b0 = 32'd8; ar0 = 0; rr0 = 0; rr1 = 1;
        wait_acc("bp");
        v0 = 0; v1 = 1; new_op(1);
        for (int i = 0; i < LAT + 1 + 5; i++) step();
        check("bp_still_busy", {31'd0, busy}, 32'd1);
        rr0 = 1;
        wait_resp("bp");
        check("bp_data", resp_val, 32'h000F_0F00);
        step();
        check("bp_next_accept", {31'd0, acc_ev}, 32'd1);
        drain();

        // Reset while the shifter is busy.
        v0 = 1; v1 = 0; a0 = 32'hFFFF_0000; b0 = 32'd1; ar0 = 1; rr0 = 1;
        wait_acc("mid_rst");
        v0 = 0;
        step();
        rst_d = 1; step(); rst_d = 0;
        step(); step();
        v0 = 1; v1 = 1; new_op(0); new_op(1);
        wait_acc("post_rst");
        check("post_rst_grant", {31'd0, acc_port}, 32'd0);
        drain();

        run_single(0, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, "zero_amt");

        // Random traffic.
        v0 = 0; v1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (v0 && $urandom_range(0, 9) == 0) v0 = 0;
            else if (!v0 && $urandom_range(0, 1) == 1) begin v0 = 1; new_op(0); end
            if (v1 && $urandom_range(0, 9) == 0) v1 = 0;
            else if (!v1 && $urandom_range(0, 1) == 1) begin v1 = 1; new_op(1); end
            rr0 = ($urandom_range(0, 9) < 7);
            rr1 = ($urandom_range(0, 9) < 7);
            step();
            if (acc_ev) begin
                new_op(acc_port);
                if ($urandom_range(0, 1) == 0) begin
                    if (acc_port) v1 = 0; else v0 = 0;
                end
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
